// File: rtl/pulse_checker.sv
// Pulse-stream interval checker: measures rise-to-rise intervals and locks
// onto a repeating 8-entry interval pattern, flagging mismatches and timeouts.
//
// state  | meaning
// HUNT   | searching the table for any entry matching the last interval
// TRACK  | following the table, counting consecutive matches toward lock
// LOCKED | stream matches the table; mismatches are flagged and tolerated once
module pulse_checker #(
  parameter int unsigned E0      = 7,
  parameter int unsigned E1      = 2,
  parameter int unsigned E2      = 9,
  parameter int unsigned E3      = 6,
  parameter int unsigned E4      = 10,
  parameter int unsigned E5      = 11,
  parameter int unsigned E6      = 20,
  parameter int unsigned E7      = 8,
  parameter int unsigned LOCK_N  = 8,
  parameter int unsigned TIMEOUT = 40
) (
  input  logic       CLK,
  input  logic       nRST,
  input  logic       PULSEi,
  output logic [5:0] INTERVALo,
  output logic       VALIDo,
  output logic       LOCKo,
  output logic [2:0] IDXo,
  output logic       ERRo,
  output logic [7:0] ERRCNTo
);

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} state_t;

  state_t     state;
  logic       p_d;
  logic       armed;
  logic [5:0] cnt;
  logic [3:0] mcnt;
  logic       miss;

  logic       rise;
  logic [5:0] meas;
  logic       hit_exp;
  logic       hit_any;
  logic [2:0] hit_idx;
  logic       lock_next;

  function automatic logic [5:0] e_at(input logic [2:0] i);
    case (i)
      3'd0:    return 6'(E0);
      3'd1:    return 6'(E1);
      3'd2:    return 6'(E2);
      3'd3:    return 6'(E3);
      3'd4:    return 6'(E4);
      3'd5:    return 6'(E5);
      3'd6:    return 6'(E6);
      default: return 6'(E7);
    endcase
  endfunction

  assign rise      = PULSEi & ~p_d;
  assign meas      = (cnt == 6'd63) ? 6'd63 : cnt + 6'd1;
  assign hit_exp   = (meas == e_at(IDXo));
  assign lock_next = ((mcnt + 4'd1) == 4'(LOCK_N));

  // Descending scan so the lowest matching index wins.
  always_comb begin
    hit_any = 1'b0;
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (meas == e_at(3'(i))) begin
        hit_any = 1'b1;
        hit_idx = 3'(i);
      end
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state     <= HUNT;
      p_d       <= 1'b0;
      armed     <= 1'b0;
      cnt       <= 6'd0;
      mcnt      <= 4'd0;
      miss      <= 1'b0;
      INTERVALo <= 6'd0;
      VALIDo    <= 1'b0;
      LOCKo     <= 1'b0;
      IDXo      <= 3'd0;
      ERRo      <= 1'b0;
      ERRCNTo   <= 8'd0;
    end else begin
      p_d    <= PULSEi;
      VALIDo <= 1'b0;
      ERRo   <= 1'b0;

      if (rise)
        cnt <= 6'd0;
      else if (cnt != 6'd63)
        cnt <= cnt + 6'd1;

      if (rise) begin
        armed <= 1'b1;
        if (armed) begin
          INTERVALo <= meas;
          VALIDo    <= 1'b1;
          case (state)
            HUNT: begin
              if (hit_any) begin
                IDXo <= hit_idx + 3'd1;
                mcnt <= 4'd1;
                if (LOCK_N == 1) begin
                  state <= LOCKED;
                  LOCKo <= 1'b1;
                end else begin
                  state <= TRACK;
                end
              end
            end
            TRACK: begin
              if (hit_exp) begin
                IDXo <= IDXo + 3'd1;
                mcnt <= mcnt + 4'd1;
                if (lock_next) begin
                  state <= LOCKED;
                  LOCKo <= 1'b1;
                end
              end else begin
                state <= HUNT;
                mcnt  <= 4'd0;
              end
            end
            LOCKED: begin
              // Advance by position even on a miss so one bad interval resyncs.
              IDXo <= IDXo + 3'd1;
              if (hit_exp) begin
                miss <= 1'b0;
              end else begin
                ERRo <= 1'b1;
                if (ERRCNTo != 8'd255) ERRCNTo <= ERRCNTo + 8'd1;
                if (miss) begin
                  state <= HUNT;
                  LOCKo <= 1'b0;
                  mcnt  <= 4'd0;
                  miss  <= 1'b0;
                end else begin
                  miss <= 1'b1;
                end
              end
            end
            default: state <= HUNT;
          endcase
        end
      end else if (cnt == 6'(TIMEOUT)) begin
        state <= HUNT;
        armed <= 1'b0;
        LOCKo <= 1'b0;
        mcnt  <= 4'd0;
        miss  <= 1'b0;
        if (state == LOCKED) begin
          ERRo <= 1'b1;
          if (ERRCNTo != 8'd255) ERRCNTo <= ERRCNTo + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pulse_checker.sv
// Scoreboard bench for pulse_checker: a time-since-last-rise reference model
// queues expected strobe events; a monitor compares them as the DUT emits them.
module tb_pulse_checker;

  localparam int LOCK_N  = 8;
  localparam int TIMEOUT = 40;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       PULSEi;
  logic [5:0] INTERVALo;
  logic       VALIDo;
  logic       LOCKo;
  logic [2:0] IDXo;
  logic       ERRo;
  logic [7:0] ERRCNTo;

  pulse_checker #(.LOCK_N(LOCK_N), .TIMEOUT(TIMEOUT)) dut (
    .CLK(CLK), .nRST(nRST), .PULSEi(PULSEi),
    .INTERVALo(INTERVALo), .VALIDo(VALIDo), .LOCKo(LOCKo),
    .IDXo(IDXo), .ERRo(ERRo), .ERRCNTo(ERRCNTo)
  );

  always #5 CLK = ~CLK;

  int E [8] = '{7, 2, 9, 6, 10, 11, 20, 8};

  int n_pass = 0;
  int n_total = 0;

  // {valid, err, interval, lock, idx, errcnt}
  logic [19:0] exp_q [$];

  int m_since, m_run, m_idx, m_ec, m_last;
  bit m_pd, m_armed, m_lock, m_miss;
  int pos;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [19:0] pack_ev(bit v, bit e, int iv, bit l, int idx, int ec);
    return {v, e, 6'(iv), l, 3'(idx), 8'(ec)};
  endfunction

  task automatic model_reset();
    m_since = 0; m_run = 0; m_idx = 0; m_ec = 0; m_last = 0;
    m_pd = 0; m_armed = 0; m_lock = 0; m_miss = 0;
  endtask

  // m_since = clock edges elapsed since the last rise, as seen at this edge.
  task automatic model_edge(input bit p);
    bit rise, err;
    int iv;
    rise = p && !m_pd;
    m_pd = p;
    m_since = (m_since >= 64) ? 64 : m_since + 1;
    if (rise) begin
      if (m_armed) begin
        iv  = (m_since > 63) ? 63 : m_since;
        err = 0;
        if (m_lock) begin
          if (iv != E[m_idx]) begin
            err = 1;
            m_ec = (m_ec >= 255) ? 255 : m_ec + 1;
            if (m_miss) begin m_lock = 0; m_run = 0; m_miss = 0; end
            else m_miss = 1;
          end else m_miss = 0;
          m_idx = (m_idx + 1) % 8;
        end else if (m_run == 0) begin
          for (int i = 0; i < 8; i++) begin
            if (m_run == 0 && iv == E[i]) begin
              m_idx = (i + 1) % 8;
              m_run = 1;
              if (m_run == LOCK_N) m_lock = 1;
            end
          end
        end else if (iv == E[m_idx]) begin
          m_idx = (m_idx + 1) % 8;
          m_run++;
          if (m_run == LOCK_N) m_lock = 1;
        end else begin
          m_run = 0;
        end
        m_last = iv;
        exp_q.push_back(pack_ev(1, err, iv, m_lock, m_idx, m_ec));
      end
      m_armed = 1;
      m_since = 0;
    end else if (m_since == TIMEOUT + 1) begin
      err = m_lock;
      if (m_lock) m_ec = (m_ec >= 255) ? 255 : m_ec + 1;
      m_lock = 0; m_run = 0; m_miss = 0; m_armed = 0;
      if (err) exp_q.push_back(pack_ev(0, 1, m_last, 0, m_idx, m_ec));
    end
  endtask

  task automatic step(input bit p);
    @(negedge CLK);
    PULSEi = p;
    model_edge(p);
  endtask

  task automatic gap_hi(input int n, input int hi);
    for (int k = 0; k < n; k++) step(k < hi);
  endtask

  task automatic gap(input int n);
    gap_hi(n, 1);
  endtask

  task automatic play();
    gap(E[pos]);
    pos = (pos + 1) % 8;
  endtask

  task automatic check_state(input string name);
    @(posedge CLK);
    #1;
    check(name, {LOCKo, IDXo, ERRCNTo}, {m_lock, 3'(m_idx), 8'(m_ec)});
  endtask

  task automatic release_rst();
    model_reset();
    nRST = 1'b1;
    PULSEi = 1'b0;
    model_edge(0);
  endtask

  initial begin
    forever begin
      @(posedge CLK);
      #2;
      if (nRST && (VALIDo || ERRo)) begin
        if (exp_q.size() == 0) begin
          n_total++;
          $display("FAIL spurious_event: got valid=%0b err=%0b interval=%0d expected no event",
                   VALIDo, ERRo, INTERVALo);
        end else begin
          check("event", {12'd0, VALIDo, ERRo, INTERVALo, LOCKo, IDXo, ERRCNTo},
                {12'd0, exp_q.pop_front()});
        end
      end
    end
  end

  initial begin
    nRST = 1'b1;
    PULSEi = 1'b0;
    model_reset();
    #1 nRST = 1'b0;
    #1;
    check("reset_outputs", {INTERVALo, VALIDo, LOCKo, IDXo, ERRo, ERRCNTo}, 20'd0);
    repeat (2) @(negedge CLK);
    release_rst();

    // Clean table stream, twice through, plus one rise to close the last interval.
    pos = 0;
    repeat (17) play();
    check_state("lock_after_table");

    // Single wrong interval while locked.
    while (pos != 2) play();
    gap(12);
    pos = 3;
    check_state("single_miss");
    repeat (8) play();

    // Two consecutive wrong intervals drop lock, then relock.
    gap(3);
    gap(4);
    pos = (pos + 2) % 8;
    check_state("double_miss_unlock");
    repeat (10) play();
    check_state("relock");

    // Silence while locked.
    repeat (50) step(0);
    check_state("timeout");
    repeat (3) play();

    // Held-high pulse and a rise coinciding with the timeout count.
    gap_hi(20, 5);
    gap(41);
    repeat (3) play();
    check_state("held_and_coincident");

    // Randomised stream: mostly correct, some wrong intervals, some silences.
    for (int g = 0; g < 400; g++) begin
      int r;
      int n;
      r = $urandom_range(0, 99);
      if (r < 85) begin
        n = E[pos];
        gap_hi(n, $urandom_range(1, (n > 3) ? 3 : n - 1));
        pos = (pos + 1) % 8;
      end else if (r < 95) begin
        gap($urandom_range(2, 50));
        pos = (pos + 1) % 8;
      end else begin
        repeat ($urandom_range(35, 55)) step(0);
      end
    end
    check_state("random_phase");

    // Resync from silence, then alternate miss/match to saturate the error count.
    repeat (50) step(0);
    pos = 0;
    repeat (10) play();
    for (int k = 0; k < 270; k++) begin
      gap(3);
      pos = (pos + 1) % 8;
      play();
    end
    check_state("errcnt_saturated");

    // Asynchronous reset between clock edges while locked.
    @(negedge CLK);
    #1 nRST = 1'b0;
    #1;
    check("async_reset_outputs", {INTERVALo, VALIDo, LOCKo, IDXo, ERRo, ERRCNTo}, 20'd0);
    check("queue_drained_before_reset", exp_q.size(), 0);
    exp_q.delete();
    @(negedge CLK);
    release_rst();
    pos = 0;
    repeat (12) play();
    check_state("after_reset_recovery");

    repeat (3) step(0);
    @(posedge CLK);
    #3;
    check("queue_drained_at_end", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pulse_checker.md
PULSE_CHECKER -- requirements
Module: pulse_checker

Interface
REQ-001 Parameter E0..E7, defaults 7, 2, 9, 6, 10, 11, 20, 8: expected rise-to-rise interval table; each value SHALL be within 2..62.
REQ-002 Parameter LOCK_N, default 8: consecutive matched intervals required to declare lock; range 1..15.
REQ-003 Parameter TIMEOUT, default 40: cycles without a rise before the link is declared lost; range 3..62.
REQ-004 CLK  input  1  sole clock; all state updates on posedge CLK.
REQ-005 nRST  input  1  reset, asynchronous assert, active-low; all state is cleared while low.
REQ-006 PULSEi  input  1  pulse stream from the upstream pulse generator, synchronous to CLK.
REQ-007 INTERVALo  output  6  last measured rise-to-rise interval in cycles, saturating at 63.
REQ-008 VALIDo  output  1  one-cycle strobe; INTERVALo updated this cycle.
REQ-009 LOCKo  output  1  high while the stream matches the table.
REQ-010 IDXo  output  3  table index expected for the next interval.
REQ-011 ERRo  output  1  one-cycle strobe on a mismatch or timeout while locked.
REQ-012 ERRCNTo  output  8  count of ERRo strobes, saturating at 255.

Function
REQ-013 Edge detect: p_d SHALL be PULSEi delayed by one register; rise = PULSEi & ~p_d; a held-high PULSEi SHALL produce exactly one rise.
REQ-014 Counter cnt[5:0]: on rise cnt <= 0; otherwise cnt <= cnt+1, saturating at 63.
REQ-015 Armed flag: set on the first rise after reset or after a timeout; the first rise SHALL NOT produce a measurement.
REQ-016 Measurement: on rise while armed, INTERVALo <= min(cnt+1, 63) and VALIDo = 1 on the same edge; VALIDo is 0 on all other cycles.
REQ-017 Two consecutive rises separated by N cycles of PULSEi low SHALL report an interval of N+1.
REQ-018 FSM states: HUNT, TRACK, LOCKED; the match evaluation below SHALL use the interval value being registered on the same edge.
REQ-019 HUNT: on a measurement equal to some E[i] (lowest i wins), go to TRACK with IDXo <= (i+1) mod 8 and mcnt <= 1; if LOCK_N = 1, go directly to LOCKED instead; no match: stay in HUNT.
REQ-020 TRACK: match E[IDXo]: IDXo++ (wrapping 7 -> 0) and mcnt++; when mcnt reaches LOCK_N, go to LOCKED with LOCKo = 1.
REQ-021 TRACK mismatch: go to HUNT, mcnt <= 0; the mismatching interval SHALL NOT be re-searched.
REQ-022 LOCKED match: IDXo++ (wrapping) and miss <= 0.
REQ-023 LOCKED mismatch: ERRo = 1, ERRCNTo++, IDXo++ (resync by position), miss++.
REQ-024 LOCKED: the second consecutive mismatch SHALL force HUNT with LOCKo = 0.
REQ-025 Timeout: cnt == TIMEOUT with no rise on that edge: go to HUNT, clear armed, LOCKo <= 0, mcnt <= 0, miss <= 0; ERRo/ERRCNTo++ only if the state was LOCKED; fires once per silence.
REQ-026 A rise on the same edge where cnt == TIMEOUT SHALL count as a normal measurement (rise wins) and SHALL NOT time out.
REQ-027 ERRCNTo at 255 SHALL hold; ERRo still pulses.
REQ-028 LOCKo SHALL be a registered output, high exactly in state LOCKED.

Reset
REQ-029 While nRST = 0: p_d, cnt, armed, mcnt, and miss SHALL all be 0.
REQ-030 While nRST = 0: INTERVALo, VALIDo, LOCKo, IDXo, ERRo, and ERRCNTo SHALL all be 0, with state = HUNT.
REQ-031 Reset asserted mid-operation (including while LOCKED) SHALL clear all state immediately, without waiting for a clock edge.
REQ-032 The first rise after reset release SHALL only arm the block.

Verification
REQ-033 Scenario: reset, then rises with gaps 7,2,9,6,10,11,20,8 repeated twice -> first VALIDo one interval after the first rise; LOCKo rises on the edge of the 8th matched interval; IDXo increments 0..7 and wraps; ERRo never asserted.
REQ-034 Scenario: locked stream, one gap changed 9 -> 12 -> single ERRo, ERRCNTo = 1, LOCKo stays 1, next correct interval matches the following entry (6).
REQ-035 Scenario: locked stream, two consecutive wrong gaps -> two ERRo strobes, LOCKo drops on the second, state HUNT, relock after 8 further matched intervals.
REQ-036 Scenario: locked stream, PULSEi held low -> timeout when cnt = 40, ERRo once, LOCKo = 0; next rise only arms the block, with no VALIDo.
REQ-037 Scenario: PULSEi held high 5 cycles, and separately a rise landing exactly at cnt = TIMEOUT -> held-high input gives exactly one rise; the coincident rise gives VALIDo with INTERVALo = 41 and no timeout.
REQ-038 Scenario: nRST pulsed low between clock edges while LOCKED with ERRCNTo = 3 -> all outputs 0 immediately, with no clock required.
